// File: rtl/bouncing_box_renderer_if.sv
// Video bundle between the sync generator, the box renderer and the DAC pins.
// Carries sync/coordinate inputs plus registered RGB, frame tick and bounce count.
// No flow control: one pixel per clock, the consumer can never stall.
interface bouncing_box_renderer_if;
  logic       iH_sync;
  logic       iV_sync;
  logic       iVideo_on;
  logic [9:0] iX;
  logic [9:0] iY;
  logic       iEN;
  logic       oH_sync;
  logic       oV_sync;
  logic [3:0] oR;
  logic [3:0] oG;
  logic [3:0] oB;
  logic       oFRAME_TICK;
  logic [7:0] oBOUNCE_CNT;

  // Sync generator / bench side.
  modport master (
    output iH_sync, iV_sync, iVideo_on, iX, iY, iEN,
    input  oH_sync, oV_sync, oR, oG, oB, oFRAME_TICK, oBOUNCE_CNT
  );

  // Renderer side.
  modport slave (
    input  iH_sync, iV_sync, iVideo_on, iX, iY, iEN,
    output oH_sync, oV_sync, oR, oG, oB, oFRAME_TICK, oBOUNCE_CNT
  );
endinterface

// File: rtl/bouncing_box_renderer.sv
// Draws a border and a bouncing square box; box moves once per frame on vsync fall.
// Latency: one clock from coordinates/syncs to RGB and delayed syncs.
// No backpressure: the pixel stream is consumed every clock.
module bouncing_box_renderer #(
  parameter int unsigned H_ACT        = 640,
  parameter int unsigned V_ACT        = 480,
  parameter int unsigned BOX          = 32,
  parameter int unsigned STEP         = 2,
  parameter int unsigned INIT_X       = 304,
  parameter int unsigned INIT_Y       = 224,
  parameter int unsigned FLASH_FRAMES = 8,
  parameter logic [11:0] BOX_COLOR    = 12'hF00,
  parameter logic [11:0] BORDER_COLOR = 12'hFFF,
  parameter logic [11:0] BG_COLOR     = 12'h00F
) (
  input  logic                    iCLK,
  input  logic                    iRST,
  bouncing_box_renderer_if.slave  vga
);

  localparam logic [10:0] XLIM   = 11'(H_ACT - BOX);
  localparam logic [10:0] YLIM   = 11'(V_ACT - BOX);
  localparam logic [10:0] STEP11 = 11'(STEP);
  localparam logic [10:0] BOX11  = 11'(BOX);
  localparam logic [9:0]  XMAX   = 10'(H_ACT - 1);
  localparam logic [9:0]  YMAX   = 10'(V_ACT - 1);

  logic [9:0]  box_x, box_y;
  logic        dx, dy;            // 1 = moving towards larger coordinates
  logic [7:0]  flash_cnt;
  logic        vs_prev;
  logic [7:0]  bounce_cnt;
  logic        frame_tick_q;
  logic [11:0] rgb_q;
  logic        hs_q, vs_q;

  logic        tick;
  logic        move;
  logic [10:0] x11, y11, nx, ny;
  logic        ndx, ndy, hit_x, hit_y, hit;
  logic        in_box, on_border;
  logic [10:0] px11, py11;
  logic [11:0] pix;

  assign x11  = {1'b0, box_x};
  assign y11  = {1'b0, box_y};
  assign tick = vs_prev & ~vga.iV_sync;
  assign move = tick & vga.iEN;

  // Next X position/direction: clamp to the edge and reverse when the step would cross it.
  always_comb begin
    nx    = x11;
    ndx   = dx;
    hit_x = 1'b0;
    if (dx) begin
      if (x11 + STEP11 >= XLIM) begin
        nx    = XLIM;
        ndx   = 1'b0;
        hit_x = 1'b1;
      end else begin
        nx = x11 + STEP11;
      end
    end else begin
      if (x11 <= STEP11) begin
        nx    = 11'd0;
        ndx   = 1'b1;
        hit_x = 1'b1;
      end else begin
        nx = x11 - STEP11;
      end
    end
  end

  // Next Y position/direction, same rules as X.
  always_comb begin
    ny    = y11;
    ndy   = dy;
    hit_y = 1'b0;
    if (dy) begin
      if (y11 + STEP11 >= YLIM) begin
        ny    = YLIM;
        ndy   = 1'b0;
        hit_y = 1'b1;
      end else begin
        ny = y11 + STEP11;
      end
    end else begin
      if (y11 <= STEP11) begin
        ny    = 11'd0;
        ndy   = 1'b1;
        hit_y = 1'b1;
      end else begin
        ny = y11 - STEP11;
      end
    end
  end

  // A corner hit is one bounce, not two.
  assign hit = move & (hit_x | hit_y);

  // Motion, bounce counting and flash timer; only the vblank tick changes position.
  always_ff @(posedge iCLK) begin
    if (iRST) begin
      box_x        <= 10'(INIT_X);
      box_y        <= 10'(INIT_Y);
      dx           <= 1'b1;
      dy           <= 1'b1;
      flash_cnt    <= 8'd0;
      vs_prev      <= 1'b1;
      bounce_cnt   <= 8'd0;
      frame_tick_q <= 1'b0;
    end else begin
      vs_prev      <= vga.iV_sync;
      frame_tick_q <= tick;
      if (move) begin
        box_x <= nx[9:0];
        box_y <= ny[9:0];
        dx    <= ndx;
        dy    <= ndy;
      end
      if (hit) begin
        bounce_cnt <= bounce_cnt + 8'd1;
        flash_cnt  <= 8'(FLASH_FRAMES);
      end else if (tick && flash_cnt != 8'd0) begin
        flash_cnt <= flash_cnt - 8'd1;
      end
    end
  end

  assign px11      = {1'b0, vga.iX};
  assign py11      = {1'b0, vga.iY};
  assign in_box    = (px11 >= x11) && (px11 < x11 + BOX11) &&
                     (py11 >= y11) && (py11 < y11 + BOX11);
  assign on_border = (vga.iX == 10'd0) || (vga.iX == XMAX) ||
                     (vga.iY == 10'd0) || (vga.iY == YMAX);

  // Pixel colour select; box wins over border.
  always_comb begin
    pix = BG_COLOR;
    if (!vga.iVideo_on)
      pix = 12'h000;
    else if (in_box)
      pix = (flash_cnt != 8'd0) ? ~BOX_COLOR : BOX_COLOR;
    else if (on_border)
      pix = BORDER_COLOR;
  end

  // Output stage: RGB and syncs share one register so they stay aligned.
  always_ff @(posedge iCLK) begin
    if (iRST) begin
      rgb_q <= 12'h000;
      hs_q  <= 1'b1;
      vs_q  <= 1'b1;
    end else begin
      rgb_q <= pix;
      hs_q  <= vga.iH_sync;
      vs_q  <= vga.iV_sync;
    end
  end

  assign vga.oR          = rgb_q[11:8];
  assign vga.oG          = rgb_q[7:4];
  assign vga.oB          = rgb_q[3:0];
  assign vga.oH_sync     = hs_q;
  assign vga.oV_sync     = vs_q;
  assign vga.oFRAME_TICK = frame_tick_q;
  assign vga.oBOUNCE_CNT = bounce_cnt;

endmodule

// File: tb/tb_bouncing_box_renderer.sv
// Directed bench for bouncing_box_renderer: three instances with different start positions.
// Checks sample 1 time unit after the rising edge; inputs change at the same point.
// Expected values are hand-computed constants.
module tb_bouncing_box_renderer;
  logic iCLK;
  logic iRST;
  int   tests;
  int   fails;

  bouncing_box_renderer_if if_a ();
  bouncing_box_renderer_if if_b ();
  bouncing_box_renderer_if if_c ();

  bouncing_box_renderer dut_a (.iCLK(iCLK), .iRST(iRST), .vga(if_a.slave));
  bouncing_box_renderer #(.INIT_X(606)) dut_b (.iCLK(iCLK), .iRST(iRST), .vga(if_b.slave));
  bouncing_box_renderer #(.INIT_X(606), .INIT_Y(446)) dut_c (.iCLK(iCLK), .iRST(iRST), .vga(if_c.slave));

  initial iCLK = 1'b0;
  always #5 iCLK = ~iCLK;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge iCLK);
    #1;
  endtask

  task automatic drive(input logic hs, input logic vs, input logic von,
                       input logic [9:0] x, input logic [9:0] y, input logic en);
    if_a.iH_sync = hs; if_a.iV_sync = vs; if_a.iVideo_on = von; if_a.iX = x; if_a.iY = y; if_a.iEN = en;
    if_b.iH_sync = hs; if_b.iV_sync = vs; if_b.iVideo_on = von; if_b.iX = x; if_b.iY = y; if_b.iEN = en;
    if_c.iH_sync = hs; if_c.iV_sync = vs; if_c.iVideo_on = von; if_c.iX = x; if_c.iY = y; if_c.iEN = en;
  endtask

  // One vsync falling edge; the frame tick must be a single-clock pulse.
  task automatic frame(input logic en);
    drive(1'b1, 1'b0, 1'b0, 10'd0, 10'd0, en);
    cyc();
    check("tick_hi", 32'(if_a.oFRAME_TICK), 32'd1);
    drive(1'b1, 1'b1, 1'b0, 10'd0, 10'd0, en);
    cyc();
    check("tick_lo", 32'(if_a.oFRAME_TICK), 32'd0);
  endtask

  // Present one pixel to all instances and let it through the output register.
  task automatic pix(input logic von, input logic [9:0] x, input logic [9:0] y);
    drive(1'b1, 1'b1, von, x, y, 1'b1);
    cyc();
  endtask

  function automatic logic [31:0] rgb(input logic [3:0] r, input logic [3:0] g, input logic [3:0] b);
    return {20'd0, r, g, b};
  endfunction

  initial begin
    tests = 0;
    fails = 0;

    // Reset with both syncs low at the inputs: outputs must still show reset values.
    iRST = 1'b1;
    drive(1'b0, 1'b0, 1'b1, 10'd304, 10'd224, 1'b1);
    cyc();
    check("rst_hs",   32'(if_a.oH_sync), 32'd1);
    check("rst_vs",   32'(if_a.oV_sync), 32'd1);
    check("rst_rgb",  rgb(if_a.oR, if_a.oG, if_a.oB), 32'h000);
    check("rst_tick", 32'(if_a.oFRAME_TICK), 32'd0);
    check("rst_cnt",  32'(if_a.oBOUNCE_CNT), 32'd0);

    // First pixel after release: box colour at the initial top-left corner.
    iRST = 1'b0;
    drive(1'b0, 1'b1, 1'b1, 10'd304, 10'd224, 1'b1);
    cyc();
    check("first_rgb", rgb(if_a.oR, if_a.oG, if_a.oB), 32'hF00);
    check("first_hs",  32'(if_a.oH_sync), 32'd0);
    check("first_vs",  32'(if_a.oV_sync), 32'd1);
    check("first_cnt", 32'(if_a.oBOUNCE_CNT), 32'd0);
    check("first_tick", 32'(if_a.oFRAME_TICK), 32'd0);

    // Static pixel classes with the box at (304,224).
    pix(1'b1, 10'd0, 10'd100);   check("border_left",  rgb(if_a.oR, if_a.oG, if_a.oB), 32'hFFF);
    pix(1'b1, 10'd639, 10'd479); check("border_br",    rgb(if_a.oR, if_a.oG, if_a.oB), 32'hFFF);
    pix(1'b1, 10'd336, 10'd224); check("right_of_box", rgb(if_a.oR, if_a.oG, if_a.oB), 32'h00F);
    pix(1'b1, 10'd335, 10'd255); check("box_br",       rgb(if_a.oR, if_a.oG, if_a.oB), 32'hF00);
    pix(1'b1, 10'd304, 10'd256); check("below_box",    rgb(if_a.oR, if_a.oG, if_a.oB), 32'h00F);
    pix(1'b0, 10'd304, 10'd224); check("video_off",    rgb(if_a.oR, if_a.oG, if_a.oB), 32'h000);
    // Box has priority over the border: C's box after its first tick sits at (608,448).

    // Tick 1 with motion enabled.
    frame(1'b1);
    pix(1'b1, 10'd306, 10'd226); check("a_moved_in",  rgb(if_a.oR, if_a.oG, if_a.oB), 32'hF00);
    pix(1'b1, 10'd304, 10'd224); check("a_old_tl",    rgb(if_a.oR, if_a.oG, if_a.oB), 32'h00F);
    check("a_x1", 32'(dut_a.box_x), 32'd306);
    check("a_y1", 32'(dut_a.box_y), 32'd226);
    check("b_x1", 32'(dut_b.box_x), 32'd608);
    check("b_dx1", 32'(dut_b.dx), 32'd0);
    check("b_cnt1", 32'(if_b.oBOUNCE_CNT), 32'd1);
    pix(1'b1, 10'd610, 10'd250); check("b_flash1", rgb(if_b.oR, if_b.oG, if_b.oB), 32'h0FF);
    check("c_x1", 32'(dut_c.box_x), 32'd608);
    check("c_y1", 32'(dut_c.box_y), 32'd448);
    check("c_dx1", 32'(dut_c.dx), 32'd0);
    check("c_dy1", 32'(dut_c.dy), 32'd0);
    check("c_cnt_corner", 32'(if_c.oBOUNCE_CNT), 32'd1);
    pix(1'b1, 10'd639, 10'd479); check("c_box_over_border", rgb(if_c.oR, if_c.oG, if_c.oB), 32'h0FF);

    // Tick 2: B moves back left, no new bounce.
    frame(1'b1);
    check("b_x2", 32'(dut_b.box_x), 32'd606);
    check("b_cnt2", 32'(if_b.oBOUNCE_CNT), 32'd1);

    // Ticks 3..8: flash still active after the 8th tick since the bounce.
    for (int i = 3; i <= 8; i++) frame(1'b1);
    pix(1'b1, 10'd610, 10'd250); check("b_flash8", rgb(if_b.oR, if_b.oG, if_b.oB), 32'h0FF);

    // Tick 9: flash over, normal colour.
    frame(1'b1);
    pix(1'b1, 10'd610, 10'd250); check("b_flash_end", rgb(if_b.oR, if_b.oG, if_b.oB), 32'hF00);
    check("a_x9", 32'(dut_a.box_x), 32'd322);
    check("a_y9", 32'(dut_a.box_y), 32'd242);
    check("b_x9", 32'(dut_b.box_x), 32'd592);

    // Three ticks with motion disabled: everything holds, pulses continue.
    for (int i = 0; i < 3; i++) frame(1'b0);
    check("hold_a_x", 32'(dut_a.box_x), 32'd322);
    check("hold_a_y", 32'(dut_a.box_y), 32'd242);
    check("hold_b_x", 32'(dut_b.box_x), 32'd592);
    check("hold_b_cnt", 32'(if_b.oBOUNCE_CNT), 32'd1);
    check("hold_c_x", 32'(dut_c.box_x), 32'd592);
    check("hold_c_dy", 32'(dut_c.dy), 32'd0);

    // Mid-line reset.
    drive(1'b0, 1'b1, 1'b1, 10'd322, 10'd242, 1'b1);
    cyc();
    check("pre_rst_rgb", rgb(if_a.oR, if_a.oG, if_a.oB), 32'hF00);
    iRST = 1'b1;
    cyc();
    check("mid_rst_rgb", rgb(if_a.oR, if_a.oG, if_a.oB), 32'h000);
    check("mid_rst_hs",  32'(if_a.oH_sync), 32'd1);
    check("mid_rst_cnt", 32'(if_b.oBOUNCE_CNT), 32'd0);
    check("mid_rst_x",   32'(dut_a.box_x), 32'd304);
    check("mid_rst_y",   32'(dut_a.box_y), 32'd224);
    iRST = 1'b0;
    drive(1'b1, 1'b1, 1'b1, 10'd304, 10'd224, 1'b1);
    cyc();
    check("post_rst_rgb", rgb(if_a.oR, if_a.oG, if_a.oB), 32'hF00);
    pix(1'b1, 10'd610, 10'd250); check("post_rst_b_noflash", rgb(if_b.oR, if_b.oG, if_b.oB), 32'hF00);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
